baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Programmable baud-rate tick generator for the UART datapath. It is the parametrised successor of the fixed single-value timer. It adds a runtime-loadable divisor, an oversampling stage with bit and mid-bit strobes, start/stop control, and a one-shot frame mode that counts a programmable number of bit periods and then flags completion. The UART TX and RX engines consume its ticks in place of per-engine timers.

## Interface

**Parameters**
- `DIV_W`, default 16: width of the divisor register and the prescaler counter.
- `OS_RATE`, default 16: oversample ticks per bit period. Must be ≥ 2; does not need to be a power of 2.
- `FB_W`, default 4: width of `frame_bits`.
- `RST_DIV`, default 650: divisor value after reset. Must fit in `DIV_W` bits.

**Ports**
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: count enable. When low, all counters freeze and tick outputs are forced low.
- `start` in 1: one-cycle request. From IDLE it enters RUN; in RUN it resynchronises.
- `stop` in 1: one-cycle request to return to IDLE.
- `mode` in 1: 0 = periodic, 1 = one-shot. Latched only on an accepted `start`.
- `frame_bits` in `FB_W`: number of bit periods in one-shot mode. Latched on `start`; value 0 is treated as 1.
- `div_load` in 1: loads `div_in` into the divisor register.
- `div_in` in `DIV_W`: new divisor value.
- `os_tick` out 1: oversample strobe.
- `mid_tick` out 1: mid-bit strobe.
- `bit_tick` out 1: end-of-bit strobe.
- `done` out 1: one-shot frame complete.
- `busy` out 1: high while in RUN.

## Operation

**Reset values**
- State IDLE; `div_q` = `RST_DIV`.
- `pcnt`, `ocnt`, `bcnt` = 0; `mode_q` = 0.
- All outputs = 0.

**State machine (IDLE, RUN)**
- IDLE → RUN on `start`.
  - Clears `pcnt` and `ocnt`.
  - Loads `bcnt` = max(`frame_bits`, 1) − 1.
  - Latches `mode` into `mode_q`.
- RUN → IDLE on `stop`. `stop` wins over a simultaneous `start`.
- RUN → IDLE in one-shot mode on the `bit_tick` where `bcnt` == 0.
- `start` while in RUN (without `stop`): stays in RUN, re-clears and reloads exactly as from IDLE. No tick is generated in that cycle.
- IDLE: counters are held at 0 and no ticks are produced.

**Prescaler**
- `act` = RUN && `en` && !`start` && !`stop`.
- `os_tick` = `act` && (`pcnt` ≥ `div_q`). On `os_tick`, `pcnt` ← 0; otherwise, when `act`, `pcnt` ← `pcnt` + 1.
- Resulting period is `div_q` + 1 enabled cycles. `div_q` = 0 gives a tick on every enabled cycle.
- The comparison is ≥, so a divisor reduced below the current `pcnt` wraps on the next active cycle rather than running through the full counter range.

**Oversampler**
- `ocnt` has width $clog2(`OS_RATE`) and counts `os_tick`s from 0 to `OS_RATE` − 1, then wraps to 0.
- `mid_tick` = `os_tick` && (`ocnt` == `OS_RATE`/2 − 1).
- `bit_tick` = `os_tick` && (`ocnt` == `OS_RATE` − 1).

**Frame counter (one-shot mode)**
- On `bit_tick` with `bcnt` > 0: `bcnt` decrements.
- On `bit_tick` with `bcnt` == 0: `done` = 1 in that same cycle, and the state returns to IDLE.
- In periodic mode `done` is always 0.

**Divisor**
- `div_load` writes `div_q` at the clock edge. It is accepted in any state, including while `en` is low.
- The new value first governs the cycle after the load.

**Other outputs**
- `busy` = (state == RUN), registered.
- `os_tick`, `mid_tick`, `bit_tick` and `done` are combinational decodes of registered state and `en`. Each is high for exactly one cycle per event.

## Timing

- Cycle R1 is the first cycle in RUN after `start` is sampled. With constant `en` = 1, the first `os_tick` falls in cycle R(`div_q` + 1).
- `bit_tick` falls every `OS_RATE`·(`div_q` + 1) cycles.
- `busy` rises in R1. In one-shot mode it falls in the cycle after `done`.
- Each `en`-low cycle delays all subsequent ticks by exactly one cycle.
- `rst_n` low at any edge forces the reset values on the next cycle, overriding every other input, including mid-frame.

## Test plan

Bench configuration: `OS_RATE` = 4, `RST_DIV` = 3.

1. Reset, then periodic `start` with `en` = 1 → `os_tick` in R4, R8, R12, R16; `mid_tick` in R8; `bit_tick` in R16 and R32; `busy` = 1 throughout; `done` = 0.
2. One-shot `start` with `frame_bits` = 2 → `bit_tick` in R16 and R32; `done` high in R32 only; `busy` low from R33; no ticks afterwards.
3. Periodic run with `en` low for 5 cycles during R2–R6 → first `os_tick` moves to R9; `pcnt` holds its value while `en` is low.
4. Running with `div_q` = 3, pulse `div_load` with `div_in` = 1 in the cycle where `pcnt` = 1 → next cycle `pcnt` = 2 ≥ 1, so `os_tick` fires there; period is 2 cycles thereafter.
5. `start` mid-run → counters return to 0 and the next `os_tick` arrives 4 cycles later. `start` and `stop` together → IDLE, `busy` = 0, no ticks.
6. `rst_n` low for one cycle during a one-shot frame, after first loading `div_q` = 7 → `busy` = 0, all ticks = 0, `div_q` = 3, `done` never asserted.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Programmable baud-rate tick generator: prescaler, oversampler and one-shot frame counter.
// Produces oversample, mid-bit and end-of-bit strobes for the UART TX/RX engines.
module baud_tick_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned OS_RATE = 16,
  parameter int unsigned FB_W    = 4,
  parameter int unsigned RST_DIV = 650
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [FB_W-1:0]  frame_bits,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic             done,
  output logic             busy
);

  localparam int unsigned OcntW = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [OcntW-1:0] OcntLast = OcntW'(OS_RATE - 1);
  localparam logic [OcntW-1:0] OcntMid  = OcntW'(OS_RATE / 2 - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   pcnt_q, pcnt_d;
  logic [OcntW-1:0]   ocnt_q, ocnt_d;
  logic [FB_W-1:0]    bcnt_q, bcnt_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               act;

  // Strobes are decodes of registered counters qualified by the current inputs.
  always_comb begin
    act      = (state_q == StRun) && en && !start && !stop;
    os_tick  = act && (pcnt_q >= div_q);
    mid_tick = os_tick && (ocnt_q == OcntMid);
    bit_tick = os_tick && (ocnt_q == OcntLast);
    done     = bit_tick && mode_q && (bcnt_q == '0);
    busy     = busy_q;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ocnt_d  = ocnt_q;
    bcnt_d  = bcnt_q;
    mode_d  = mode_q;
    div_d   = div_load ? div_in : div_q;

    if (stop) begin
      state_d = StIdle;
      pcnt_d  = '0;
      ocnt_d  = '0;
      bcnt_d  = '0;
    end else if (start) begin
      state_d = StRun;
      pcnt_d  = '0;
      ocnt_d  = '0;
      bcnt_d  = (frame_bits == '0) ? '0 : frame_bits - FB_W'(1);
      mode_d  = mode;
    end else if (state_q == StRun) begin
      if (os_tick) begin
        pcnt_d = '0;
        ocnt_d = (ocnt_q == OcntLast) ? '0 : ocnt_q + OcntW'(1);
        if (bit_tick && mode_q) begin
          if (bcnt_q == '0) begin
            state_d = StIdle;
            ocnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q - FB_W'(1);
          end
        end
      end else if (act) begin
        pcnt_d = pcnt_q + DIV_W'(1);
      end
    end

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= DIV_W'(RST_DIV);
      pcnt_q  <= '0;
      ocnt_q  <= '0;
      bcnt_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pcnt_q  <= pcnt_d;
      ocnt_q  <= ocnt_d;
      bcnt_q  <= bcnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen (OS_RATE=4, RST_DIV=3); expected output vectors
// {os_tick, mid_tick, bit_tick, done, busy} are queued per cycle and checked at negedge.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, start, stop, mode, div_load;
  logic [3:0]  frame_bits;
  logic [15:0] div_in;
  logic        os_tick, mid_tick, bit_tick, done, busy;

  logic [4:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  baud_tick_gen #(
    .DIV_W  (16),
    .OS_RATE(4),
    .FB_W   (4),
    .RST_DIV(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .frame_bits(frame_bits),
    .div_load  (div_load),
    .div_in    (div_in),
    .os_tick   (os_tick),
    .mid_tick  (mid_tick),
    .bit_tick  (bit_tick),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] Zero = 5'b00000;
  localparam logic [4:0] Busy = 5'b00001;
  localparam logic [4:0] Os   = 5'b10001;

  // Periodic run with div_q=3, OS_RATE=4: os every 4, mid at 8 mod 16, bit at 0 mod 16.
  function automatic logic [4:0] pexp(input int r);
    return {(r % 4) == 0, (r % 16) == 8, (r % 16) == 0, 1'b0, 1'b1};
  endfunction

  task automatic cycle(input logic [4:0] e, input string tag);
    logic [4:0] want;
    logic [4:0] obs;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    obs  = {os_tick, mid_tick, bit_tick, done, busy};
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] e;
    rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    frame_bits = 4'd0; div_load = 1'b0; div_in = 16'd0;
    @(posedge clk);
    #1;
    cycle(Zero, "reset");

    // 1: periodic run
    rst_n = 1'b1; start = 1'b1; mode = 1'b0;
    cycle(Zero, "t1_start");
    start = 1'b0;
    for (int r = 1; r <= 32; r++) cycle(pexp(r), $sformatf("t1_R%0d", r));

    // 2: one-shot, two bit periods, restarted from RUN
    start = 1'b1; mode = 1'b1; frame_bits = 4'd2;
    cycle(Busy, "t2_start");
    start = 1'b0;
    for (int r = 1; r <= 32; r++) begin
      e = pexp(r);
      e[1] = (r == 32);
      cycle(e, $sformatf("t2_R%0d", r));
    end
    for (int r = 33; r <= 37; r++) cycle(Zero, $sformatf("t2_R%0d", r));

    // 3: en low during R2..R6
    start = 1'b1; mode = 1'b0;
    cycle(Zero, "t3_start");
    start = 1'b0;
    cycle(Busy, "t3_R1");
    en = 1'b0;
    for (int r = 2; r <= 6; r++) cycle(Busy, $sformatf("t3_R%0d", r));
    en = 1'b1;
    cycle(Busy, "t3_R7");
    cycle(Busy, "t3_R8");
    cycle(Os, "t3_R9");
    for (int r = 10; r <= 12; r++) cycle(Busy, $sformatf("t3_R%0d", r));
    cycle(5'b11001, "t3_R13_mid");

    // 4: divisor 3 -> 1 loaded while pcnt=1
    cycle(Busy, "t4_R14");
    div_load = 1'b1; div_in = 16'd1;
    cycle(Busy, "t4_R15_load");
    div_load = 1'b0;
    cycle(Os, "t4_R16");
    cycle(Busy, "t4_R17");
    cycle(5'b10101, "t4_R18_bit");
    cycle(Busy, "t4_R19");
    cycle(Os, "t4_R20");

    // 5: restart mid-run, then start+stop together
    div_load = 1'b1; div_in = 16'd3;
    cycle(Busy, "t5_load");
    div_load = 1'b0;
    cycle(Busy, "t5_pre");
    start = 1'b1;
    cycle(Busy, "t5_restart");
    start = 1'b0;
    for (int r = 1; r <= 4; r++) cycle((r == 4) ? Os : Busy, $sformatf("t5_S%0d", r));
    start = 1'b1; stop = 1'b1;
    cycle(Busy, "t5_startstop");
    start = 1'b0; stop = 1'b0;
    for (int r = 0; r < 3; r++) cycle(Zero, $sformatf("t5_idle%0d", r));

    // 6: reset mid one-shot frame after loading div_q=7
    div_load = 1'b1; div_in = 16'd7;
    cycle(Zero, "t6_load");
    div_load = 1'b0;
    start = 1'b1; mode = 1'b1; frame_bits = 4'd1;
    cycle(Zero, "t6_start");
    start = 1'b0;
    for (int r = 1; r <= 4; r++) cycle(Busy, $sformatf("t6_R%0d", r));
    rst_n = 1'b0;
    cycle(Busy, "t6_rst_cycle");
    rst_n = 1'b1;
    for (int r = 0; r < 10; r++) cycle(Zero, $sformatf("t6_post%0d", r));
    start = 1'b1; mode = 1'b0;
    cycle(Zero, "t6_restart");
    start = 1'b0;
    for (int r = 1; r <= 8; r++) cycle(pexp(r), $sformatf("t6_div_R%0d", r));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
